// File: rtl/ovl_window_pkg.sv
// Shared types and helpers for the multi-channel window checker.
// The optional coverage counter is enabled with OVL_WINDOW_COVER_EN.
package ovl_window_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } chan_state_e;

    // One bit per violation kind, reported by each channel per cycle
    typedef struct packed {
        logic expr;
        logic min;
        logic max;
    } fire_t;

    // Length counter must reach the larger bound plus headroom for saturation
    function automatic int len_width(input int max_len, input int min_len);
        int hi;
        hi = (max_len > min_len) ? max_len : min_len;
        return $clog2(hi + 2);
    endfunction

    // a + b clamped to lim (all values treated as unsigned)
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/ovl_window_chan.sv
// One window-checker channel: IDLE/OPEN FSM, length counter, registered fires.
// With OVL_WINDOW_COVER_EN a registered clean-close pulse is also produced.
module ovl_window_chan
    import ovl_window_pkg::*;
#(
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  start_event,
    input  logic  end_event,
    input  logic  test_expr,
`ifdef OVL_WINDOW_COVER_EN
    output logic  clean_close,
`endif
    output fire_t fire_code
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_TOP = '1;

    chan_state_e      state, state_n;
    logic [LEN_W-1:0] len, len_n, len_inc;
    logic             expr_flag, flag_n;
    fire_t            fire_n;
    logic             clean_n;

    // State, counter and fire registers; fires are one-cycle pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            expr_flag <= 1'b0;
            fire_code <= '0;
`ifdef OVL_WINDOW_COVER_EN
            clean_close <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            len       <= len_n;
            expr_flag <= flag_n;
            fire_code <= fire_n;
`ifdef OVL_WINDOW_COVER_EN
            clean_close <= clean_n;
`endif
        end
    end

    // Next-state and violation decode; end_event beats the MAX abort
    always_comb begin
        state_n = state;
        len_n   = len;
        flag_n  = expr_flag;
        fire_n  = '0;
        clean_n = 1'b0;
        len_inc = (len == LEN_TOP) ? len : len + LEN_W'(1);
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_event) begin
                        state_n = OPEN;
                        len_n   = '0;
                        flag_n  = 1'b0;
                    end
                end
                OPEN: begin
                    len_n = len_inc;
                    if (!test_expr && !expr_flag) begin
                        fire_n.expr = 1'b1;
                        flag_n      = 1'b1;
                    end
                    if (end_event) begin
                        state_n = IDLE;
                        if (len_inc < MIN_L)
                            fire_n.min = 1'b1;
                        else if (!flag_n)
                            clean_n = 1'b1;
                    end else if (MAX_LEN != 0 && len_inc == MAX_L) begin
                        fire_n.max = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifndef OVL_WINDOW_COVER_EN
    // clean_n only feeds the coverage counter
    logic unused_clean;
    assign unused_clean = clean_n;
`endif

endmodule

// File: rtl/ovl_window_bounded.sv
// Multi-channel bounded window checker: NUM_CH independent channels plus a
// shared saturating error counter. OVL_WINDOW_COVER_EN adds cov_windows.
module ovl_window_bounded
    import ovl_window_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] start_event,
    input  logic [NUM_CH-1:0] end_event,
    input  logic [NUM_CH-1:0] test_expr,
    output logic [NUM_CH-1:0] fire_expr,
    output logic [NUM_CH-1:0] fire_min,
    output logic [NUM_CH-1:0] fire_max,
    output logic [NUM_CH-1:0] fire,
    output logic [CNT_W-1:0]  err_count
`ifdef OVL_WINDOW_COVER_EN
    ,
    output logic [CNT_W-1:0]  cov_windows
`endif
);

    localparam int          LEN_W   = len_width(MAX_LEN, MIN_LEN);
    localparam logic [31:0] CNT_LIM = 32'((64'd1 << CNT_W) - 64'd1);

    fire_t             chan_fire [NUM_CH];
    logic [31:0]       fire_cnt;
`ifdef OVL_WINDOW_COVER_EN
    logic [NUM_CH-1:0] chan_clean;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        ovl_window_chan #(
            .MIN_LEN (MIN_LEN),
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .start_event (start_event[g]),
            .end_event   (end_event[g]),
            .test_expr   (test_expr[g]),
`ifdef OVL_WINDOW_COVER_EN
            .clean_close (chan_clean[g]),
`endif
            .fire_code   (chan_fire[g])
        );
        assign fire_expr[g] = chan_fire[g].expr;
        assign fire_min[g]  = chan_fire[g].min;
        assign fire_max[g]  = chan_fire[g].max;
    end

    assign fire = fire_expr | fire_min | fire_max;

    // Total fire pulses visible this cycle across all channels and kinds
    always_comb begin
        fire_cnt = 32'($countones(fire_expr)) + 32'($countones(fire_min))
                 + 32'($countones(fire_max));
    end

    // Error total lags the fire pulses by one cycle; frozen while disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (enable)
            err_count <= CNT_W'(sat_add(32'(err_count), fire_cnt, CNT_LIM));
    end

`ifdef OVL_WINDOW_COVER_EN
    // Count of windows closed by end_event without any violation
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cov_windows <= '0;
        else if (enable)
            cov_windows <= CNT_W'(sat_add(32'(cov_windows),
                                          32'($countones(chan_clean)), CNT_LIM));
    end
`endif

endmodule

// File: tb/tb_ovl_window_bounded.sv
// Scoreboard bench for ovl_window_bounded: driver + window model push expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_ovl_window_bounded;

    localparam int NCH  = 2;
    localparam int MINL = 2;
    localparam int MAXL = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [NCH-1:0] start_event = '0;
    logic [NCH-1:0] end_event = '0;
    logic [NCH-1:0] test_expr = '1;
    logic [NCH-1:0] fire_expr, fire_min, fire_max, fire;
    logic [CW-1:0]  err_count;
`ifdef OVL_WINDOW_COVER_EN
    logic [CW-1:0]  cov_windows;
`endif

    ovl_window_bounded #(
        .NUM_CH (NCH), .MIN_LEN (MINL), .MAX_LEN (MAXL), .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start_event (start_event),
        .end_event   (end_event),
        .test_expr   (test_expr),
        .fire_expr   (fire_expr),
        .fire_min    (fire_min),
        .fire_max    (fire_max),
        .fire        (fire),
`ifdef OVL_WINDOW_COVER_EN
        .cov_windows (cov_windows),
`endif
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NCH-1:0] fe;
        logic [NCH-1:0] fmin;
        logic [NCH-1:0] fmax;
        int             err;
        int             cov;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   finish_req = 0;

    // Reference model: a window is "open since edge start"; its length at
    // edge c is simply c - start.
    bit             m_open [NCH];
    int             m_start [NCH];
    bit             m_rep [NCH];
    logic [NCH-1:0] m_fe, m_fmin, m_fmax, m_clean;
    int             m_err, m_cov, cyc;

    function automatic int clamp(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_open[c] = 0; m_start[c] = 0; m_rep[c] = 0;
        end
        m_fe = '0; m_fmin = '0; m_fmax = '0; m_clean = '0;
        m_err = 0; m_cov = 0; cyc = 0;
    endtask

    // Drive one cycle (called at a negedge), predict post-edge outputs, push
    task automatic step(input bit en, input logic [NCH-1:0] s,
                        input logic [NCH-1:0] e, input logic [NCH-1:0] t);
        logic [NCH-1:0] nfe, nfmin, nfmax, nclean;
        int             wlen;
        exp_t           x;
        enable = en; start_event = s; end_event = e; test_expr = t;
        nfe = '0; nfmin = '0; nfmax = '0; nclean = '0;
        if (en) begin
            m_err = clamp(m_err + $countones(m_fe) + $countones(m_fmin)
                          + $countones(m_fmax));
            m_cov = clamp(m_cov + $countones(m_clean));
        end
        for (int c = 0; c < NCH; c++) begin
            if (!en) begin
                m_open[c] = 0;
            end else if (m_open[c]) begin
                wlen = cyc - m_start[c];
                if (!t[c] && !m_rep[c]) begin
                    nfe[c] = 1'b1; m_rep[c] = 1;
                end
                if (e[c]) begin
                    m_open[c] = 0;
                    if (wlen < MINL) nfmin[c] = 1'b1;
                    else if (!m_rep[c]) nclean[c] = 1'b1;
                end else if (wlen == MAXL) begin
                    nfmax[c] = 1'b1; m_open[c] = 0;
                end
            end else if (s[c]) begin
                m_open[c] = 1; m_start[c] = cyc; m_rep[c] = 0;
            end
        end
        m_fe = nfe; m_fmin = nfmin; m_fmax = nfmax; m_clean = nclean;
        cyc++;
        x.fe = nfe; x.fmin = nfmin; x.fmax = nfmax; x.err = m_err; x.cov = m_cov;
        q.push_back(x);
        @(negedge clock);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a negedge
    task automatic pulse_reset(input int ncyc);
        #2 reset = 1'b1;
        model_reset();
        repeat (ncyc) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: zero outputs under reset, else scoreboard compare per cycle
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clock or posedge reset);
            #1;
            if (finish_req) begin
                chk("scoreboard_drained", q.size(), 0);
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
            if (reset) begin
                chk("rst_fire", int'(fire), 0);
                chk("rst_fire_expr", int'(fire_expr), 0);
                chk("rst_fire_min", int'(fire_min), 0);
                chk("rst_fire_max", int'(fire_max), 0);
                chk("rst_err_count", int'(err_count), 0);
`ifdef OVL_WINDOW_COVER_EN
                chk("rst_cov_windows", int'(cov_windows), 0);
`endif
            end else if (q.size() > 0) begin
                x = q.pop_front();
                chk("fire_expr", int'(fire_expr), int'(x.fe));
                chk("fire_min", int'(fire_min), int'(x.fmin));
                chk("fire_max", int'(fire_max), int'(x.fmax));
                chk("fire", int'(fire), int'(x.fe | x.fmin | x.fmax));
                chk("err_count", int'(err_count), x.err);
`ifdef OVL_WINDOW_COVER_EN
                chk("cov_windows", int'(cov_windows), x.cov);
`endif
            end
        end
    end

    initial begin : driver
        logic [NCH-1:0] s, e, t;
        bit en;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Legal window on ch0: length 4
        step(1, 2'b01, 2'b00, 2'b11);
        repeat (3) step(1, 2'b00, 2'b00, 2'b11);
        step(1, 2'b00, 2'b01, 2'b11);
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);

        // Expression drop on ch0 for 3 cycles: one fire_expr
        step(1, 2'b01, 2'b00, 2'b11);
        step(1, 2'b00, 2'b00, 2'b11);
        repeat (3) step(1, 2'b00, 2'b00, 2'b10);
        step(1, 2'b00, 2'b00, 2'b11);
        step(1, 2'b00, 2'b01, 2'b11);
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);

        // Short window on ch1
        step(1, 2'b10, 2'b00, 2'b11);
        step(1, 2'b00, 2'b10, 2'b11);
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);

        // Overlong window on ch0, then a stray end_event
        step(1, 2'b01, 2'b00, 2'b11);
        repeat (10) step(1, 2'b00, 2'b00, 2'b11);
        step(1, 2'b00, 2'b01, 2'b11);
        step(1, 2'b00, 2'b00, 2'b11);

        // Simultaneous short windows on both channels until saturation
        repeat (10) begin
            step(1, 2'b11, 2'b00, 2'b11);
            step(1, 2'b00, 2'b11, 2'b11);
        end
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);

        // Reset mid-window, then end alone, then start+end in IDLE opens
        step(1, 2'b01, 2'b00, 2'b11);
        step(1, 2'b00, 2'b00, 2'b11);
        pulse_reset(2);
        step(1, 2'b00, 2'b01, 2'b11);
        step(1, 2'b01, 2'b01, 2'b11);
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);
        step(1, 2'b00, 2'b01, 2'b11);
        repeat (2) step(1, 2'b00, 2'b00, 2'b11);

        // Enable drop mid-window
        step(1, 2'b11, 2'b00, 2'b11);
        step(1, 2'b00, 2'b00, 2'b00);
        step(0, 2'b00, 2'b11, 2'b11);
        step(1, 2'b00, 2'b11, 2'b11);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset(int'($urandom_range(1, 2)));
            en = ($urandom_range(0, 49) != 0);
            for (int c = 0; c < NCH; c++) begin
                s[c] = ($urandom_range(0, 3) == 0);
                e[c] = ($urandom_range(0, 4) == 0);
                t[c] = ($urandom_range(0, 11) != 0);
            end
            step(en, s, e, t);
        end

        repeat (2) @(negedge clock);
        finish_req = 1;
        repeat (5) @(posedge clock);
        $display("FAIL watchdog: monitor did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ovl_window_bounded.md
Name: ovl_window_bounded

Overview:
- Multi-channel, parametrised successor to the single-channel window checker.
- Each channel opens a window on start_event and closes it on end_event.
- Per channel, the block checks that:
  - test_expr holds throughout the window;
  - window length (cycles) lies in [MIN_LEN, MAX_LEN].
- Sits beside DUT interfaces in OVL benches. Registered per-channel fire pulses and a shared saturating error counter feed the UVM scoreboard.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- MIN_LEN, 1: minimum legal window length in cycles (>=1).
- MAX_LEN, 16: maximum legal window length in cycles. 0 = unbounded (max check disabled). If nonzero, must be >=MIN_LEN.
- CNT_W, 8: width of error/coverage counters.

Ports:
- clock  in  1  sampling clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global check enable.
- start_event  in  NUM_CH  per-channel window open request.
- end_event  in  NUM_CH  per-channel window close.
- test_expr  in  NUM_CH  per-channel expression that must be 1 inside the window.
- fire_expr  out  NUM_CH  pulse: test_expr low inside window.
- fire_min  out  NUM_CH  pulse: window closed too early.
- fire_max  out  NUM_CH  pulse: window exceeded MAX_LEN.
- fire  out  NUM_CH  fire_expr | fire_min | fire_max.
- err_count  out  CNT_W  saturating total of fire pulses.

Behaviour:
- Reset state:
  - While reset=1, all outputs are 0, all channels are IDLE, all counters are 0.
  - Reset is asynchronous both on assertion and mid-window.
  - The first check happens on the first rising edge after reset deasserts.
- enable=0: all channels are forced to IDLE and no fires are generated. err_count holds its value.
- Per-channel FSM, states IDLE and OPEN. Each channel has a length counter len, width clog2(max(MAX_LEN,MIN_LEN)+2).
- IDLE:
  - start_event=1 -> OPEN, len=0, expr_flag=0.
  - end_event is ignored in IDLE. If start_event and end_event are both 1 in IDLE, start wins and end is ignored.
- OPEN, evaluated on each edge:
  - len_n = len+1, saturating.
  - test_expr=0 with expr_flag=0 -> fire_expr pulse and expr_flag=1. This reports at most once per window.
  - test_expr is checked in every OPEN cycle, including the cycle in which end_event is sampled.
  - end_event=1 -> IDLE. If len_n < MIN_LEN -> fire_min pulse.
  - Else if MAX_LEN!=0 and len_n == MAX_LEN and end_event=0 -> fire_max pulse, then IDLE (window aborted).
  - start_event in OPEN is ignored; there is no re-trigger.
- A violation sampled at edge N drives its fire bit high during cycle N+1 for exactly one cycle.
- fire_expr can coincide with fire_min or fire_max on the same cycle.
- err_count:
  - Adds the popcount of (fire_expr, fire_min, fire_max) across all channels each cycle.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - The update is registered: err_count reflects the fire pulses of the same cycle one cycle later.
- Channels are fully independent; there is no cross-channel interaction except err_count.

Optional Feature:
- Macro: OVL_WINDOW_COVER_EN.
- Defined:
  - Adds output cov_windows [CNT_W].
  - It is a saturating count of windows that closed via end_event with no fire of any kind.
  - Reset value 0; it holds while enable=0.
- Undefined: the port and its counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package ovl_window_pkg holds:
  - the state enum (IDLE, OPEN);
  - a fire-code typedef (EXPR, MIN, MAX) as a 3-bit struct;
  - the length-counter width function;
  - a saturating-add helper function.
- One sub-module, ovl_window_chan, holds one channel's FSM, len counter and fire registers.
- The top level instantiates NUM_CH copies via generate, and owns err_count and cov_windows.

Test Plan (NUM_CH=2, MIN_LEN=2, MAX_LEN=8, CNT_W=4):
- Legal window: ch0 start, test_expr=1, end 4 cycles later.
  - No fire on any channel; err_count stays 0; cov_windows=1 when the macro is defined.
- Expression drop: ch0 test_expr=0 for 3 cycles mid-window.
  - fire_expr[0] pulses exactly once, one cycle after the first low sample; err_count=1.
- Short window: ch1 end_event on the cycle after start (len 1).
  - fire_min[1] single pulse; ch1 returns to IDLE.
- Overlong window: ch0 start, no end.
  - fire_max[0] pulses after the 8th OPEN cycle; ch0 is IDLE; a later end_event produces no fire.
- Simultaneous violations and saturation:
  - Both channels violate on the same edge -> err_count increments by 2.
  - Repeating this until 15 -> err_count stays 15.
- Reset mid-window: reset=1 during OPEN.
  - All outputs 0 immediately, without waiting for a clock.
  - After release, end_event alone produces no fire; start/end in the same IDLE cycle opens a window.
